alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
//  Parametrised multi-cycle ALU for the datapath. It extends the 16-bit AND/OR/ADD/SUB/SLT/NOR
//  unit with shifts, an iterative unsigned multiply, Zero and Error flags and a valid/ready handshake.
//  It sits between the register-file read ports and the writeback stage. When a MUL is in flight,
//  the block holds off new operands until that MUL completes.
// PARAMETERS
//  WIDTH   16  datapath width in bits (>=4)
//  MUL_EN  1   1: MUL implemented; 0: MUL code treated as illegal
// PORTS
//  clk        in   1      clock, all state updates on posedge
//  reset      in   1      asynchronous, active-high reset
//  in_valid   in   1      operands/Control valid
//  in_ready   out  1      block can accept an operation (high only in IDLE)
//  ReadData1  in   WIDTH  operand A
//  ReadData2  in   WIDTH  operand B (low $clog2(WIDTH) bits = shift amount for shifts)
//  Control    in   4      operation code
//  out_valid  out  1      result valid, held until out_ready
//  out_ready  in   1      downstream accepts result
//  WriteData  out  WIDTH  result, stable while out_valid
//  Overflow   out  1      signed overflow (ADD/SUB) or product truncation (MUL)
//  Zero       out  1      WriteData == 0
//  Error      out  1      illegal Control code; WriteData = 0 for that op
// BEHAVIOUR
//  Control codes:
//   0000 AND | 0001 OR | 0010 ADD | 0110 SUB | 0111 SLT (signed, result 0/1) | 1100 NOR
//   0011 SLL | 0100 SRL | 0101 SRA | 1000 MUL (unsigned, low WIDTH bits of product)
//   All other codes are illegal.
//  Reset: state=IDLE; in_ready=1 after release; out_valid, WriteData, Overflow, Zero, Error = 0.
//  FSM IDLE/BUSY/DONE; transfer occurs when valid && ready on the same posedge.
//   IDLE: on accept, a MUL (with MUL_EN=1) latches operands and moves to BUSY. Any other code
//     computes and registers the result and flags, then moves to DONE (latency 1 cycle).
//   BUSY: one shift-add step per cycle for WIDTH cycles, then registers the result and moves
//     to DONE (accept-to-out_valid latency = WIDTH+1 cycles).
//   DONE: out_valid=1; outputs frozen; moves to IDLE on out_ready. No accept in the same cycle:
//     in_ready rises the cycle after out_ready.
//  in_ready = (state==IDLE). Inputs are ignored outside IDLE.
//  Arithmetic rules:
//   ADD/SUB wrap modulo 2^WIDTH. Overflow = sign(A)==sign(B') && sign(R)!=sign(A),
//     where B' = B for ADD and ~B+1 for SUB.
//   SLT compares signed, so Overflow=0. Logic ops and shifts also give Overflow=0.
//   Shift amount = B[$clog2(WIDTH)-1:0]; upper bits of B are ignored. SRA replicates A[WIDTH-1].
//   MUL: Overflow = |product[2*WIDTH-1:WIDTH].
//  Illegal code: goes to DONE with Error=1, WriteData=0, Overflow=0, Zero=1.
//  Reset asserted mid-MUL or in DONE aborts the operation; the result is lost and nothing is
//  produced. No $display in RTL.
// STRUCTURE
//  alu_pkg: localparams for all Control codes, FSM state encodings, and a function for
//   shift-amount width.
//  Sub-module alu_mul_iter: shift-add multiplier with ports clk, reset, start, a, b, busy,
//   done, product[2*WIDTH-1:0]. Instantiated only when MUL_EN=1 (generate).
//  Combinational single-cycle op mux plus flag logic in alu_mc; result register shared by
//   all ops.
// TESTING (WIDTH=16)
//  ADD 0x7FFF+0x0001, out_ready=1 -> 1 cycle later WriteData=0x8000, Overflow=1, Zero=0.
//  SUB 0x1234-0x1234 -> WriteData=0x0000, Zero=1, Overflow=0.
//  SLT A=0xFFFF, B=0x0001 -> 1. SRA 0x8000 by B=0x0013 -> 0xF000 (amount 3).
//  MUL 0x0102*0x0003 -> out_valid after 17 cycles, WriteData=0x0306, Overflow=0, and in_ready=0
//   throughout. MUL 0x0100*0x0100 -> WriteData=0, Overflow=1.
//  Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0. Assert reset at MUL cycle
//   8 -> all outputs 0, IDLE, no out_valid.
//  Control=4'b1111 -> Error=1, WriteData=0. With MUL_EN=0, Control=1000 -> Error=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: operation codes, FSM states and
// the shift-amount width helper.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } alu_state_t;

    function automatic int shamt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// WIDTH cycles after start, with a one-cycle done pulse.
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (start && !busy) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= CW'(WIDTH);
            busy   <= 1'b1;
            done   <= 1'b0;
        end else if (busy) begin
            if (mplier[0])
                acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            // last step: acc holds the full product on the edge done rises
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

    assign product = acc;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake, single-cycle logic/arith/shift
// ops and an optional iterative multiplier sharing one result register.
//   state  | meaning
//   IDLE   | in_ready high, waiting for an operation
//   BUSY   | multiplier iterating, inputs ignored
//   DONE   | out_valid high, outputs frozen until out_ready
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ReadData1,
    input  logic [WIDTH-1:0] ReadData2,
    input  logic [3:0]       Control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] WriteData,
    output logic             Overflow,
    output logic             Zero,
    output logic             Error
);
    localparam int         SW  = shamt_width(WIDTH);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    alu_state_t         state;
    logic               accept;
    logic               is_mul;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH-1:0]   res;
    logic               res_ovf;
    logic               res_err;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   bneg;
    logic [WIDTH-1:0]   diff;
    logic [SW-1:0]      shamt;

    assign accept = in_valid && in_ready;
    assign is_mul = (Control == OP_MUL) && (MUL_EN != 0);

    generate
        if (MUL_EN != 0) begin : g_mul
            alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
                .clk     (clk),
                .reset   (reset),
                .start   (accept && is_mul),
                .a       (ReadData1),
                .b       (ReadData2),
                .busy    (mul_busy),
                .done    (mul_done),
                .product (mul_product)
            );
        end else begin : g_nomul
            assign mul_busy    = 1'b0;
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    assign sum   = ReadData1 + ReadData2;
    assign bneg  = ~ReadData2 + ONE;
    assign diff  = ReadData1 + bneg;
    assign shamt = ReadData2[SW-1:0];

    always_comb begin
        res     = '0;
        res_ovf = 1'b0;
        res_err = 1'b0;
        case (Control)
            OP_AND: res = ReadData1 & ReadData2;
            OP_OR:  res = ReadData1 | ReadData2;
            OP_NOR: res = ~(ReadData1 | ReadData2);
            OP_ADD: begin
                res     = sum;
                res_ovf = (ReadData1[WIDTH-1] == ReadData2[WIDTH-1]) &&
                          (sum[WIDTH-1] != ReadData1[WIDTH-1]);
            end
            OP_SUB: begin
                res     = diff;
                res_ovf = (ReadData1[WIDTH-1] == bneg[WIDTH-1]) &&
                          (diff[WIDTH-1] != ReadData1[WIDTH-1]);
            end
            OP_SLT: res = ($signed(ReadData1) < $signed(ReadData2)) ? ONE : '0;
            OP_SLL: res = ReadData1 << shamt;
            OP_SRL: res = ReadData1 >> shamt;
            OP_SRA: res = $signed(ReadData1) >>> shamt;
            default: res_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            WriteData <= '0;
            Overflow  <= 1'b0;
            Zero      <= 1'b0;
            Error     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && !mul_busy) begin
                        in_ready <= 1'b0;
                        if (is_mul) begin
                            state <= S_BUSY;
                        end else begin
                            WriteData <= res;
                            Overflow  <= res_ovf;
                            Zero      <= (res == '0);
                            Error     <= res_err;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_BUSY: begin
                    if (mul_done) begin
                        WriteData <= mul_product[WIDTH-1:0];
                        Overflow  <= |mul_product[2*WIDTH-1:WIDTH];
                        Zero      <= (mul_product[WIDTH-1:0] == '0);
                        Error     <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: one instance with the multiplier, one without.
module tb_alu_mc;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid0 = 1'b0;
    logic          in_valid1 = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [3:0]    ctl = 4'b0000;
    logic          out_ready = 1'b1;

    logic          in_ready0, out_valid0, ovf0, zero0, err0;
    logic [W-1:0]  wd0;
    logic          in_ready1, out_valid1, ovf1, zero1, err1;
    logic [W-1:0]  wd1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W), .MUL_EN(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
        .ReadData1(a), .ReadData2(b), .Control(ctl),
        .out_valid(out_valid0), .out_ready(out_ready), .WriteData(wd0),
        .Overflow(ovf0), .Zero(zero0), .Error(err0)
    );

    alu_mc #(.WIDTH(W), .MUL_EN(0)) dut_nomul (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .ReadData1(a), .ReadData2(b), .Control(ctl),
        .out_valid(out_valid1), .out_ready(out_ready), .WriteData(wd1),
        .Overflow(ovf1), .Zero(zero1), .Error(err1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // present one op at a negedge, return #1 after the accepting posedge
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [3:0] ic, input bit to_nomul);
        @(negedge clk);
        a   = ia;
        b   = ib;
        ctl = ic;
        if (to_nomul) in_valid1 = 1'b1;
        else          in_valid0 = 1'b1;
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] ewd,
                                input logic eovf, input logic ezero, input logic eerr);
        chk({tag, ".valid"}, {31'b0, out_valid0}, 32'd1);
        chk({tag, ".wd"},    {16'b0, wd0},        {16'b0, ewd});
        chk({tag, ".ovf"},   {31'b0, ovf0},       {31'b0, eovf});
        chk({tag, ".zero"},  {31'b0, zero0},      {31'b0, ezero});
        chk({tag, ".err"},   {31'b0, err0},       {31'b0, eerr});
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        step();
        chk({tag, ".drain_valid"}, {31'b0, out_valid0}, 32'd0);
        chk({tag, ".drain_ready"}, {31'b0, in_ready0},  32'd1);
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst.in_ready", {31'b0, in_ready0}, 32'd1);
        chk("rst.valid",    {31'b0, out_valid0}, 32'd0);
        chk("rst.wd",       {16'b0, wd0}, 32'd0);
        chk("rst.flags",    {29'b0, ovf0, zero0, err0}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("post_rst.in_ready", {31'b0, in_ready0}, 32'd1);

        // single-cycle ops, out_ready held high
        out_ready = 1'b1;
        issue(16'h7FFF, 16'h0001, 4'b0010, 1'b0);
        check_result("add_ovf", 16'h8000, 1'b1, 1'b0, 1'b0);
        chk("add_ovf.in_ready", {31'b0, in_ready0}, 32'd0);
        drain("add_ovf");

        issue(16'h1234, 16'h1234, 4'b0110, 1'b0);
        check_result("sub_zero", 16'h0000, 1'b0, 1'b1, 1'b0);
        drain("sub_zero");

        issue(16'h8000, 16'h0001, 4'b0110, 1'b0);
        check_result("sub_ovf", 16'h7FFF, 1'b1, 1'b0, 1'b0);
        drain("sub_ovf");

        issue(16'hFFFF, 16'h0001, 4'b0111, 1'b0);
        check_result("slt", 16'h0001, 1'b0, 1'b0, 1'b0);
        drain("slt");

        issue(16'h0001, 16'hFFFF, 4'b0111, 1'b0);
        check_result("slt_false", 16'h0000, 1'b0, 1'b1, 1'b0);
        drain("slt_false");

        issue(16'h8000, 16'h0013, 4'b0101, 1'b0);
        check_result("sra", 16'hF000, 1'b0, 1'b0, 1'b0);
        drain("sra");

        issue(16'h8000, 16'h0014, 4'b0100, 1'b0);
        check_result("srl", 16'h0800, 1'b0, 1'b0, 1'b0);
        drain("srl");

        issue(16'h0001, 16'hFFF4, 4'b0011, 1'b0);
        check_result("sll", 16'h0010, 1'b0, 1'b0, 1'b0);
        drain("sll");

        issue(16'h0F0F, 16'h00FF, 4'b1100, 1'b0);
        check_result("nor", 16'hF000, 1'b0, 1'b0, 1'b0);
        drain("nor");

        issue(16'h0F0F, 16'h00FF, 4'b0000, 1'b0);
        check_result("and", 16'h000F, 1'b0, 1'b0, 1'b0);
        drain("and");

        // multiply: 17 cycles accept-to-valid, in_ready low throughout
        issue(16'h0102, 16'h0003, 4'b1000, 1'b0);
        chk("mul.c0_valid", {31'b0, out_valid0}, 32'd0);
        chk("mul.c0_ready", {31'b0, in_ready0}, 32'd0);
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("mul.c%0d_valid", k), {31'b0, out_valid0}, 32'd0);
            chk($sformatf("mul.c%0d_ready", k), {31'b0, in_ready0}, 32'd0);
        end
        step();
        check_result("mul", 16'h0306, 1'b0, 1'b0, 1'b0);
        drain("mul");

        issue(16'h0100, 16'h0100, 4'b1000, 1'b0);
        repeat (17) step();
        check_result("mul_ovf", 16'h0000, 1'b1, 1'b1, 1'b0);
        drain("mul_ovf");

        // DONE held with out_ready low
        out_ready = 1'b0;
        issue(16'h00F0, 16'h0F00, 4'b0001, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check_result($sformatf("hold%0d", k), 16'h0FF0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("hold%0d.in_ready", k), {31'b0, in_ready0}, 32'd0);
            step();
        end
        check_result("hold_end", 16'h0FF0, 1'b0, 1'b0, 1'b0);
        drain("hold");

        // reset during multiply
        issue(16'h0102, 16'h0003, 4'b1000, 1'b0);
        repeat (7) step();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort.valid", {31'b0, out_valid0}, 32'd0);
        chk("abort.wd",    {16'b0, wd0}, 32'd0);
        chk("abort.flags", {29'b0, ovf0, zero0, err0}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            chk($sformatf("abort.c%0d_valid", k), {31'b0, out_valid0}, 32'd0);
        end
        chk("abort.in_ready", {31'b0, in_ready0}, 32'd1);

        // illegal code, then a legal op clears Error
        issue(16'h1234, 16'h5678, 4'b1111, 1'b0);
        check_result("illegal", 16'h0000, 1'b0, 1'b1, 1'b1);
        drain("illegal");
        issue(16'h0001, 16'h0001, 4'b0010, 1'b0);
        check_result("after_illegal", 16'h0002, 1'b0, 1'b0, 1'b0);
        drain("after_illegal");

        // MUL code on the instance built without a multiplier
        issue(16'h0102, 16'h0003, 4'b1000, 1'b1);
        chk("nomul.valid", {31'b0, out_valid1}, 32'd1);
        chk("nomul.err",   {31'b0, err1}, 32'd1);
        chk("nomul.wd",    {16'b0, wd1}, 32'd0);
        chk("nomul.zero",  {31'b0, zero1}, 32'd1);
        chk("nomul.ovf",   {31'b0, ovf1}, 32'd0);
        chk("nomul.ready", {31'b0, in_ready1}, 32'd0);
        step();
        chk("nomul.drain", {31'b0, out_valid1}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
